// File: rtl/axi_rw_arbiter_pkg.sv
// Shared types for the AXI read/write arbiter: FSM state encoding and watchdog width.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package axi_arb_pkg;

  localparam int WDOG_W = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_RESP = 3'd2,
    RD_ADDR = 3'd3,
    RD_DATA = 3'd4
  } arb_state_t;

  // True for the two states in which a write transaction owns the bridge.
  function automatic logic is_wr_state(arb_state_t s);
    return (s == WR_ADDR) || (s == WR_RESP);
  endfunction

  // True for the two states in which a read transaction owns the bridge.
  function automatic logic is_rd_state(arb_state_t s);
    return (s == RD_ADDR) || (s == RD_DATA);
  endfunction

endpackage

// File: rtl/axi_rw_arbiter_if.sv
// AXI address handshakes (master side and bridge side) plus monitored data/response handshakes.
// Latency: n/a (wiring only).
// Backpressure: ready/valid pairs carried unchanged; gating happens in the arbiter.
interface axi_rw_arbiter_if;

  // Master-side address channels
  logic aw_valid_m;
  logic aw_ready_m;
  logic ar_valid_m;
  logic ar_ready_m;

  // Bridge-side address channels
  logic aw_valid_s;
  logic aw_ready_s;
  logic ar_valid_s;
  logic ar_ready_s;

  // Monitored data/response handshakes
  logic w_valid;
  logic w_ready;
  logic b_valid;
  logic b_ready;
  logic r_valid;
  logic r_ready;
  logic r_last;

  // Arbiter view: gates the address channels, watches everything else.
  modport slave (
    input  aw_valid_m, ar_valid_m, aw_ready_s, ar_ready_s,
    input  w_valid, w_ready, b_valid, b_ready, r_valid, r_ready, r_last,
    output aw_ready_m, ar_ready_m, aw_valid_s, ar_valid_s
  );

  // Environment view: the AXI master and the bridge together.
  modport master (
    output aw_valid_m, ar_valid_m, aw_ready_s, ar_ready_s,
    output w_valid, w_ready, b_valid, b_ready, r_valid, r_ready, r_last,
    input  aw_ready_m, ar_ready_m, aw_valid_s, ar_valid_s
  );

endinterface

// File: rtl/axi_rw_arbiter_wdog.sv
// Idle-cycle watchdog for the response/data phases of the arbiter.
// Latency: expire is combinational from the registered count (fires in the cycle count==limit).
// Backpressure: none; any clear (handshake) in the same cycle suppresses expire.
module axi_arb_wdog
  import axi_arb_pkg::*;
(
  input  logic              a_clk,
  input  logic              a_reset,
  input  logic              run,
  input  logic              clear,
  input  logic [WDOG_W-1:0] limit,
  output logic              expire
);

  logic [WDOG_W-1:0] cnt_q;
  logic [WDOG_W-1:0] cnt_d;

  // Count idle cycles while running; outside a monitored phase the count parks at zero.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (!run || clear) begin
      cnt_d = '0;
    end
  end

  // Count register.
  always_ff @(posedge a_clk) begin
    if (a_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = run && !clear && (cnt_q == limit);

endmodule

// File: rtl/axi_rw_arbiter.sv
// Serializes AXI reads and writes onto one AHB bridge, one transaction outstanding, with a watchdog.
// Latency: one cycle from request sampled in IDLE to gated address valid; gating itself is combinational.
// Backpressure: address ready/valid pass through only in the owning ADDR state; held at 0 elsewhere.
module axi_rw_arbiter
  import axi_arb_pkg::*;
#(
  parameter int TIMEOUT  = 1024,
  parameter bit WR_FIRST = 1'b1
) (
  input  logic              a_clk,
  input  logic              a_reset,
  axi_rw_arbiter_if.slave   bus,
  output logic              grant_wr,
  output logic              grant_rd,
  output logic              timeout
);

  localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(TIMEOUT - 1);

  arb_state_t state_q;
  arb_state_t state_d;
  logic       last_wr_q;
  logic       last_wr_d;
  logic       timeout_q;
  logic       timeout_d;

  logic aw_hs;
  logic ar_hs;
  logic w_hs;
  logic b_hs;
  logic r_hs;
  logic r_done;
  logic wd_run;
  logic wd_clear;
  logic wd_expire;

  // Address gating: only the owning ADDR state lets the handshake through.
  assign bus.aw_valid_s = bus.aw_valid_m & (state_q == WR_ADDR);
  assign bus.aw_ready_m = bus.aw_ready_s & (state_q == WR_ADDR);
  assign bus.ar_valid_s = bus.ar_valid_m & (state_q == RD_ADDR);
  assign bus.ar_ready_m = bus.ar_ready_s & (state_q == RD_ADDR);

  assign aw_hs  = bus.aw_valid_s & bus.aw_ready_s;
  assign ar_hs  = bus.ar_valid_s & bus.ar_ready_s;
  assign w_hs   = bus.w_valid & bus.w_ready;
  assign b_hs   = bus.b_valid & bus.b_ready;
  assign r_hs   = bus.r_valid & bus.r_ready;
  assign r_done = r_hs & bus.r_last;

  // The watchdog only guards the phases where the far side may stall forever;
  // it restarts on phase entry and on every sign of life on W, B or R.
  assign wd_run   = (state_q == WR_RESP) || (state_q == RD_DATA);
  assign wd_clear = w_hs | b_hs | r_hs | aw_hs | ar_hs;

  axi_arb_wdog u_wdog (
    .a_clk   (a_clk),
    .a_reset (a_reset),
    .run     (wd_run),
    .clear   (wd_clear),
    .limit   (WDOG_LIMIT),
    .expire  (wd_expire)
  );

  // Next-state, fairness and timeout decisions.
  always_comb begin
    state_d   = state_q;
    last_wr_d = last_wr_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        // On contention the direction not granted last wins.
        if (bus.aw_valid_m && (!bus.ar_valid_m || !last_wr_q)) begin
          state_d   = WR_ADDR;
          last_wr_d = 1'b1;
        end else if (bus.ar_valid_m) begin
          state_d   = RD_ADDR;
          last_wr_d = 1'b0;
        end
      end
      WR_ADDR: begin
        if (aw_hs) state_d = WR_RESP;
      end
      WR_RESP: begin
        if (b_hs) begin
          state_d = IDLE;
        end else if (wd_expire) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end
      end
      RD_ADDR: begin
        if (ar_hs) state_d = RD_DATA;
      end
      RD_DATA: begin
        if (r_done) begin
          state_d = IDLE;
        end else if (wd_expire) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, last-grant and timeout-pulse registers; reset primes last-grant so the
  // first contention goes to the WR_FIRST direction.
  always_ff @(posedge a_clk) begin
    if (a_reset) begin
      state_q   <= IDLE;
      last_wr_q <= ~WR_FIRST;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_wr_q <= last_wr_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant_wr = is_wr_state(state_q);
  assign grant_rd = is_rd_state(state_q);
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_axi_rw_arbiter.sv
// Directed bench for axi_rw_arbiter with a grant-order scoreboard.
// Latency: n/a.
// Backpressure: bridge address ready held high; B/R handshakes driven explicitly.
module tb_axi_rw_arbiter;
  import axi_arb_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic grant_wr;
  logic grant_rd;
  logic timeout;

  int   total  = 0;
  int   passed = 0;
  logic exp_q[$];

  axi_rw_arbiter_if bus();

  axi_rw_arbiter #(.TIMEOUT(8), .WR_FIRST(1'b1)) dut (
    .a_clk    (clk),
    .a_reset  (rst),
    .bus      (bus.slave),
    .grant_wr (grant_wr),
    .grant_rd (grant_rd),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Called in an address-phase cycle: exactly one bridge handshake must be visible,
  // and its direction must be the next one queued when the requests were raised.
  task automatic sb_check(input string tag);
    logic [31:0] dir;
    logic        e;
    chk({tag, "_sb_hs"}, 32'(bus.aw_valid_s & bus.aw_ready_s) + 32'(bus.ar_valid_s & bus.ar_ready_s), 32'd1);
    dir = 32'(bus.aw_valid_s & bus.aw_ready_s);
    e   = 1'bx;
    if (exp_q.size() != 0) e = exp_q.pop_front();
    chk({tag, "_sb_dir"}, dir, {31'b0, e});
  endtask

  task automatic set_b(input logic v);
    bus.b_valid = v;
    bus.b_ready = v;
  endtask

  task automatic set_r(input logic v, input logic last);
    bus.r_valid = v;
    bus.r_ready = v;
    bus.r_last  = last;
  endtask

  initial begin
    rst = 1'b1;
    bus.aw_valid_m = 1'b1;
    bus.ar_valid_m = 1'b1;
    bus.aw_ready_s = 1'b1;
    bus.ar_ready_s = 1'b1;
    bus.w_valid = 1'b0;
    bus.w_ready = 1'b0;
    set_b(1'b0);
    set_r(1'b0, 1'b0);

    // Reset with both requests and both bridge readies high: everything gated off.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_grant_wr", grant_wr, 0);
    chk("rst_grant_rd", grant_rd, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_aw_valid_s", bus.aw_valid_s, 0);
    chk("rst_ar_valid_s", bus.ar_valid_s, 0);
    chk("rst_aw_ready_m", bus.aw_ready_m, 0);
    chk("rst_ar_ready_m", bus.ar_ready_m, 0);

    // Contention from reset: write first, then read, then write again.
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b0);
    rst = 1'b0;
    @(negedge clk); #1;
    chk("cont1_grant_wr", grant_wr, 1);
    chk("cont1_grant_rd", grant_rd, 0);
    chk("cont1_ar_valid_s", bus.ar_valid_s, 0);
    sb_check("cont1");
    @(negedge clk); bus.aw_valid_m = 1'b0; set_b(1'b1); #1;
    chk("cont1_wr_resp", dut.state_q, WR_RESP);
    @(negedge clk); set_b(1'b0); bus.aw_valid_m = 1'b1; exp_q.push_back(1'b1); #1;
    chk("cont1_idle", {grant_wr, grant_rd}, 0);
    @(negedge clk); #1;
    chk("cont2_grant_rd", grant_rd, 1);
    chk("cont2_aw_valid_s", bus.aw_valid_s, 0);
    sb_check("cont2");
    @(negedge clk); bus.ar_valid_m = 1'b0; set_r(1'b1, 1'b1);
    @(negedge clk); set_r(1'b0, 1'b0); bus.ar_valid_m = 1'b1; exp_q.push_back(1'b0); #1;
    chk("cont2_idle", {grant_wr, grant_rd}, 0);
    @(negedge clk); #1;
    chk("cont3_grant_wr", grant_wr, 1);
    chk("cont3_grant_rd", grant_rd, 0);
    sb_check("cont3");
    @(negedge clk); bus.aw_valid_m = 1'b0; set_b(1'b1);
    @(negedge clk); set_b(1'b0); #1;
    chk("cont3_idle", {grant_wr, grant_rd}, 0);
    @(negedge clk); #1;
    chk("cont4_grant_rd", grant_rd, 1);
    sb_check("cont4");
    @(negedge clk); bus.ar_valid_m = 1'b0; set_r(1'b1, 1'b1);
    @(negedge clk); set_r(1'b0, 1'b0); #1;
    chk("cont4_idle", {grant_wr, grant_rd}, 0);

    // Single write: request in cycle 0, gated valid in cycle 1, WR_RESP in cycle 2.
    bus.aw_valid_m = 1'b1; exp_q.push_back(1'b1);
    @(negedge clk); #1;
    chk("sw_aw_valid_s", bus.aw_valid_s, 1);
    chk("sw_aw_ready_m", bus.aw_ready_m, 1);
    chk("sw_grant_rd_c1", grant_rd, 0);
    sb_check("sw");
    @(negedge clk); bus.aw_valid_m = 1'b0; #1;
    chk("sw_wr_resp", dut.state_q, WR_RESP);
    chk("sw_aw_ready_m_resp", bus.aw_ready_m, 0);
    chk("sw_grant_wr_resp", grant_wr, 1);
    bus.b_valid = 1'b1;
    @(negedge clk); #1;
    chk("sw_b_no_ready", grant_wr, 1);
    bus.b_ready = 1'b1;
    @(negedge clk); set_b(1'b0); #1;
    chk("sw_idle", dut.state_q, IDLE);
    chk("sw_grant_wr_done", grant_wr, 0);
    chk("sw_grant_rd_done", grant_rd, 0);

    // Read burst of four beats, r_last on the fourth.
    bus.ar_valid_m = 1'b1; exp_q.push_back(1'b0);
    @(negedge clk); #1;
    chk("burst_ar_valid_s", bus.ar_valid_s, 1);
    chk("burst_ar_ready_m", bus.ar_ready_m, 1);
    sb_check("burst");
    @(negedge clk); bus.ar_valid_m = 1'b0;
    for (int b = 1; b <= 4; b++) begin
      set_r(1'b1, (b == 4));
      #1;
      chk("burst_grant_rd_beat", grant_rd, 1);
      @(negedge clk);
    end
    set_r(1'b0, 1'b0); #1;
    chk("burst_grant_rd_drop", grant_rd, 0);

    // Write with B never arriving: pulse 8 cycles after entering WR_RESP.
    bus.aw_valid_m = 1'b1; exp_q.push_back(1'b1);
    @(negedge clk); #1;
    sb_check("to");
    @(negedge clk); bus.aw_valid_m = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("to_quiet", timeout, 0);
      chk("to_hold", grant_wr, 1);
      @(negedge clk);
    end
    #1;
    chk("to_pulse", timeout, 1);
    chk("to_idle", dut.state_q, IDLE);
    @(negedge clk); #1;
    chk("to_one_cycle", timeout, 0);

    // Read: a mid-burst beat restarts the count, and the last beat lands on the expiry cycle.
    bus.ar_valid_m = 1'b1; exp_q.push_back(1'b0);
    @(negedge clk); #1;
    sb_check("exp");
    @(negedge clk); bus.ar_valid_m = 1'b0;
    for (int k = 0; k < 12; k++) begin
      set_r((k == 3) || (k == 11), (k == 11));
      #1;
      chk("exp_quiet", timeout, 0);
      chk("exp_hold", grant_rd, 1);
      @(negedge clk);
    end
    set_r(1'b0, 1'b0); #1;
    chk("exp_no_pulse", timeout, 0);
    chk("exp_idle", dut.state_q, IDLE);
    @(negedge clk); #1;
    chk("exp_no_pulse_late", timeout, 0);

    // Reset during RD_DATA with a write waiting.
    bus.ar_valid_m = 1'b1; exp_q.push_back(1'b0);
    @(negedge clk); #1;
    sb_check("rr_rd");
    @(negedge clk); bus.ar_valid_m = 1'b0;
    @(negedge clk);
    @(negedge clk); rst = 1'b1; bus.aw_valid_m = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #1;
      chk("rr_grant_wr", grant_wr, 0);
      chk("rr_grant_rd", grant_rd, 0);
      chk("rr_timeout", timeout, 0);
      chk("rr_gated", {bus.aw_valid_s, bus.ar_valid_s, bus.aw_ready_m, bus.ar_ready_m}, 0);
    end
    rst = 1'b0; exp_q.push_back(1'b1);
    @(negedge clk); #1;
    chk("rr_first_grant", grant_wr, 1);
    chk("rr_aw_valid_s", bus.aw_valid_s, 1);
    sb_check("rr_wr");
    @(negedge clk); bus.aw_valid_m = 1'b0; set_b(1'b1);
    @(negedge clk); set_b(1'b0); #1;
    chk("rr_idle", {grant_wr, grant_rd}, 0);
    chk("sb_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
